// File: rtl/axi2ahb_cmd_q.sv
// axi2ahb_cmd_q: arbitrates AXI AW/AR address channels into a single
// command FIFO feeding an AHB master. Each queued entry carries the burst
// fields plus a protocol-error flag computed at acceptance.
// Optional build macro AXI2AHB_CMD_4K_CHECK_EN adds a 4KB-boundary error
// check for INCR bursts; without it no 4KB logic exists.
module axi2ahb_cmd_q #(
    parameter int AXI_ID_WIDTH   = 1,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int CMD_FIFO_DEPTH = 4,
    parameter int ARB_MODE       = 0
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic [AXI_ID_WIDTH-1:0]       AWID,
    input  logic [AXI_ADDR_WIDTH-1:0]     AWADDR,
    input  logic [7:0]                    AWLEN,
    input  logic [2:0]                    AWSIZE,
    input  logic [1:0]                    AWBURST,
    input  logic                          AWVALID,
    output logic                          AWREADY,
    input  logic [AXI_ID_WIDTH-1:0]       ARID,
    input  logic [AXI_ADDR_WIDTH-1:0]     ARADDR,
    input  logic [7:0]                    ARLEN,
    input  logic [2:0]                    ARSIZE,
    input  logic [1:0]                    ARBURST,
    input  logic                          ARVALID,
    output logic                          ARREADY,
    output logic [AXI_ID_WIDTH-1:0]       cmd_id_o,
    output logic                          cmd_write_o,
    output logic [AXI_ADDR_WIDTH-1:0]     cmd_addr_o,
    output logic [7:0]                    cmd_len_o,
    output logic [2:0]                    cmd_size_o,
    output logic [1:0]                    cmd_burst_o,
    output logic                          cmd_error_o,
    output logic                          cmd_valid_o,
    input  logic                          cmd_ready_i,
    output logic [$clog2(CMD_FIFO_DEPTH):0] cmd_level_o
);

    localparam int IDX_W    = $clog2(CMD_FIFO_DEPTH);
    localparam int PTR_W    = IDX_W + 1;
    localparam int ENT_W    = AXI_ID_WIDTH + 1 + AXI_ADDR_WIDTH + 8 + 3 + 2 + 1;
    localparam int MAX_SIZE = $clog2(AXI_DATA_WIDTH / 8);

    // Protocol checks on the burst fields; the command is still queued.
    function automatic logic calc_error(
        input logic [AXI_ADDR_WIDTH-1:0] addr,
        input logic [7:0]                len,
        input logic [2:0]                size,
        input logic [1:0]                burst
    );
        logic                      err;
        logic                      wrap_len_ok;
        logic [AXI_ADDR_WIDTH-1:0] mask;
`ifdef AXI2AHB_CMD_4K_CHECK_EN
        logic [16:0]               span;
        logic [16:0]               last_byte;
`endif
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        mask        = (AXI_ADDR_WIDTH'(1) << size) - AXI_ADDR_WIDTH'(1);
        err         = (size > 3'(MAX_SIZE)) || (burst == 2'b11);
        err         = err || ((burst == 2'b10) && !wrap_len_ok);
        err         = err || ((burst == 2'b10) && ((addr & mask) != '0));
`ifdef AXI2AHB_CMD_4K_CHECK_EN
        // 17 bits: worst case 0xFFF + (256 << 7) cannot overflow.
        span      = (17'({9'd0, len}) + 17'd1) << size;
        last_byte = 17'({5'd0, addr[11:0]}) + span;
        err       = err || ((burst == 2'b01) && (last_byte > 17'd4096));
`endif
        return err;
    endfunction

    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [ENT_W-1:0] mem_q [CMD_FIFO_DEPTH];
    logic             last_w_q;   // last granted channel was write
    logic             lock_q;     // a granted channel is stalled by full
    logic             lock_w_q;   // which channel is stalled

    logic             full_s, empty_s, push_s, pop_s;
    logic             gnt_any_s, gnt_w_s;
    logic [ENT_W-1:0] ent_s, head_s;

    assign full_s  = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                     (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    assign empty_s = (wr_ptr_q == rd_ptr_q);

    // Channel grant: a stalled grant sticks, otherwise arbitrate by mode.
    always_comb begin
        gnt_any_s = 1'b0;
        gnt_w_s   = 1'b0;
        if (lock_q && (lock_w_q ? AWVALID : ARVALID)) begin
            gnt_any_s = 1'b1;
            gnt_w_s   = lock_w_q;
        end else if (AWVALID && ARVALID) begin
            gnt_any_s = 1'b1;
            gnt_w_s   = (ARB_MODE == 1) ? 1'b1 : !last_w_q;
        end else if (AWVALID) begin
            gnt_any_s = 1'b1;
            gnt_w_s   = 1'b1;
        end else if (ARVALID) begin
            gnt_any_s = 1'b1;
            gnt_w_s   = 1'b0;
        end else begin
            gnt_any_s = 1'b0;
            gnt_w_s   = 1'b0;
        end
    end

    // Readies are forced low while reset is asserted, not just after an edge.
    assign push_s  = ARESETN && gnt_any_s && !full_s;
    assign AWREADY = push_s && gnt_w_s;
    assign ARREADY = push_s && !gnt_w_s;
    assign pop_s   = !empty_s && cmd_ready_i;

    assign ent_s = gnt_w_s ?
        {AWID, 1'b1, AWADDR, AWLEN, AWSIZE, AWBURST, calc_error(AWADDR, AWLEN, AWSIZE, AWBURST)} :
        {ARID, 1'b0, ARADDR, ARLEN, ARSIZE, ARBURST, calc_error(ARADDR, ARLEN, ARSIZE, ARBURST)};

    // Data outputs read zero whenever the queue is empty.
    assign head_s = empty_s ? '0 : mem_q[rd_ptr_q[IDX_W-1:0]];
    assign {cmd_id_o, cmd_write_o, cmd_addr_o, cmd_len_o,
            cmd_size_o, cmd_burst_o, cmd_error_o} = head_s;
    assign cmd_valid_o = !empty_s;
    assign cmd_level_o = wr_ptr_q - rd_ptr_q;

    // FIFO pointers; the extra MSB distinguishes full from empty.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_s) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_s)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    // Command storage, written at the tail on accept.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < CMD_FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else if (push_s) begin
            mem_q[wr_ptr_q[IDX_W-1:0]] <= ent_s;
        end
    end

    // Arbitration history: last winner moves only on accept; lock tracks stalls.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            last_w_q <= 1'b0;
            lock_q   <= 1'b0;
            lock_w_q <= 1'b0;
        end else begin
            if (push_s) last_w_q <= gnt_w_s;
            lock_q   <= gnt_any_s && full_s;
            lock_w_q <= gnt_w_s;
        end
    end

endmodule

// File: tb/tb_axi2ahb_cmd_q.sv
// Directed bench for axi2ahb_cmd_q with a queue-based reference model that
// is compared against the DUT on every falling clock edge.
module tb_axi2ahb_cmd_q;

    typedef struct packed {
        logic [0:0]  id;
        logic        w;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        err;
    } cmd_t;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [0:0]  AWID = 1'b0, ARID = 1'b0;
    logic [31:0] AWADDR = 32'd0, ARADDR = 32'd0;
    logic [7:0]  AWLEN = 8'd0, ARLEN = 8'd0;
    logic [2:0]  AWSIZE = 3'd0, ARSIZE = 3'd0;
    logic [1:0]  AWBURST = 2'd0, ARBURST = 2'd0;
    logic        AWVALID = 1'b0, ARVALID = 1'b0;
    logic        cmd_ready_i = 1'b0;

    logic        AWREADY, ARREADY, cmd_write_o, cmd_error_o, cmd_valid_o;
    logic [0:0]  cmd_id_o;
    logic [31:0] cmd_addr_o;
    logic [7:0]  cmd_len_o;
    logic [2:0]  cmd_size_o;
    logic [1:0]  cmd_burst_o;
    logic [2:0]  cmd_level_o;

    logic        awr1, arr1, wr1, err1, val1;
    logic [0:0]  id1;
    logic [31:0] addr1;
    logic [7:0]  len1;
    logic [2:0]  size1, lvl1;
    logic [1:0]  burst1;

    int total = 0;
    int bad   = 0;

    always #5 ACLK = ~ACLK;

    axi2ahb_cmd_q #(.ARB_MODE(0)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .cmd_id_o(cmd_id_o), .cmd_write_o(cmd_write_o), .cmd_addr_o(cmd_addr_o),
        .cmd_len_o(cmd_len_o), .cmd_size_o(cmd_size_o), .cmd_burst_o(cmd_burst_o),
        .cmd_error_o(cmd_error_o), .cmd_valid_o(cmd_valid_o),
        .cmd_ready_i(cmd_ready_i), .cmd_level_o(cmd_level_o)
    );

    axi2ahb_cmd_q #(.ARB_MODE(1)) dut_wp (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(awr1),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(arr1),
        .cmd_id_o(id1), .cmd_write_o(wr1), .cmd_addr_o(addr1),
        .cmd_len_o(len1), .cmd_size_o(size1), .cmd_burst_o(burst1),
        .cmd_error_o(err1), .cmd_valid_o(val1),
        .cmd_ready_i(cmd_ready_i), .cmd_level_o(lvl1)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Error rules stated with plain integer arithmetic (32-bit data bus).
    function automatic bit model_err(input logic [31:0] addr, input int len, input int size, input int burst);
        int beats;
        beats = len + 1;
        if ((1 << size) > 4) return 1'b1;
        if (burst == 3) return 1'b1;
        if (burst == 2 && !(beats == 2 || beats == 4 || beats == 8 || beats == 16)) return 1'b1;
        if (burst == 2 && (addr % (1 << size)) != 0) return 1'b1;
`ifdef AXI2AHB_CMD_4K_CHECK_EN
        if (burst == 1 && (int'(addr % 4096) + beats * (1 << size)) > 4096) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // Reference model: expected queue contents plus arbitration memory.
    cmd_t q[$];
    int   m_last = 0;    // 0 = read last, 1 = write last
    int   m_hold = -1;   // channel stalled by full: -1 none, 0 read, 1 write

    initial begin : model_compare
        int   g;
        bit   full, pop;
        cmd_t head, c;
        forever begin
            @(negedge ACLK);
            if (!ARESETN) begin
                check("rst_awready", AWREADY, 0);
                check("rst_arready", ARREADY, 0);
                check("rst_valid", cmd_valid_o, 0);
                check("rst_level", cmd_level_o, 0);
                check("rst_data", {cmd_id_o, cmd_write_o, cmd_addr_o, cmd_len_o,
                                   cmd_size_o, cmd_burst_o, cmd_error_o}, 0);
                q.delete();
                m_last = 0;
                m_hold = -1;
            end else begin
                if (m_hold == 1 && AWVALID) g = 1;
                else if (m_hold == 0 && ARVALID) g = 0;
                else if (AWVALID && ARVALID) g = (m_last == 1) ? 0 : 1;
                else if (AWVALID) g = 1;
                else if (ARVALID) g = 0;
                else g = -1;
                full = (q.size() == 4);
                check("m_awready", AWREADY, (g == 1) && !full);
                check("m_arready", ARREADY, (g == 0) && !full);
                check("m_valid", cmd_valid_o, q.size() != 0);
                check("m_level", cmd_level_o, q.size());
                head = (q.size() != 0) ? q[0] : '0;
                check("m_head", {cmd_id_o, cmd_write_o, cmd_addr_o, cmd_len_o,
                                 cmd_size_o, cmd_burst_o, cmd_error_o}, head);
                pop = (q.size() != 0) && cmd_ready_i;
                if (pop) void'(q.pop_front());
                if (g >= 0 && !full) begin
                    if (g == 1) c = '{AWID, 1'b1, AWADDR, AWLEN, AWSIZE, AWBURST,
                                      model_err(AWADDR, AWLEN, AWSIZE, AWBURST)};
                    else        c = '{ARID, 1'b0, ARADDR, ARLEN, ARSIZE, ARBURST,
                                      model_err(ARADDR, ARLEN, ARSIZE, ARBURST)};
                    q.push_back(c);
                    m_last = g;
                end
                m_hold = (g >= 0 && full) ? g : -1;
            end
        end
    end

    task automatic cyc();
        @(posedge ACLK);
        #1;
    endtask

    task automatic set_fields(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s, input logic [1:0] b);
        AWADDR = a; ARADDR = a; AWLEN = l; ARLEN = l;
        AWSIZE = s; ARSIZE = s; AWBURST = b; ARBURST = b;
    endtask

    // Offer one write and wait (bounded) for acceptance; AWVALID stays high.
    task automatic offer_w(input logic [31:0] a, input int budget, output bit ok);
        ok = 1'b0;
        set_fields(a, 8'd0, 3'd2, 2'b01);
        AWID = 1'b1;
        AWVALID = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge ACLK);
            ok = AWREADY;
            cyc();
            if (ok) break;
        end
    endtask

    // Queue one command (empty queue, cmd_ready_i low), check it, pop it.
    task automatic send(input bit w, input logic [31:0] a, input logic [7:0] l,
                        input logic [2:0] s, input logic [1:0] b, input bit exp_err, input string nm);
        bit ok;
        ok = 1'b0;
        set_fields(a, l, s, b);
        AWID = 1'b0; ARID = 1'b1;
        if (w) AWVALID = 1'b1; else ARVALID = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge ACLK);
            ok = w ? AWREADY : ARREADY;
            cyc();
            if (ok) break;
        end
        AWVALID = 1'b0; ARVALID = 1'b0;
        check({nm, "_accept"}, ok, 1);
        @(negedge ACLK);
        check({nm, "_err"}, cmd_error_o, exp_err);
        check({nm, "_addr"}, cmd_addr_o, a);
        cyc();
        cmd_ready_i = 1'b1;
        cyc();
        cmd_ready_i = 1'b0;
    endtask

    task automatic do_reset();
        ARESETN = 1'b0;
        cyc(); cyc();
        ARESETN = 1'b1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        bit          ok;
        bit          exp_w[4];
        logic [31:0] exp_a[4];
        bit          e4k;

        do_reset();
        @(negedge ACLK);
        check("reset_valid", cmd_valid_o, 0);
        check("reset_level", cmd_level_o, 0);

        // single write with cmd_ready_i high
        cyc();
        cmd_ready_i = 1'b1;
        set_fields(32'h100, 8'd3, 3'd2, 2'b01);
        AWID = 1'b1;
        AWVALID = 1'b1;
        @(negedge ACLK);
        check("single_awready", AWREADY, 1);
        cyc();
        AWVALID = 1'b0;
        @(negedge ACLK);
        check("single_valid", cmd_valid_o, 1);
        check("single_write", cmd_write_o, 1);
        check("single_addr", cmd_addr_o, 32'h100);
        check("single_len", cmd_len_o, 3);
        check("single_err", cmd_error_o, 0);
        cyc();

        // contention, both modes
        do_reset();
        exp_w[0] = 1'b1; exp_w[1] = 1'b0; exp_w[2] = 1'b1; exp_w[3] = 1'b0;
        cmd_ready_i = 1'b1;
        set_fields(32'h200, 8'd0, 3'd2, 2'b01);
        AWVALID = 1'b1; ARVALID = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge ACLK);
            check("rr_awready", AWREADY, exp_w[i]);
            check("rr_arready", ARREADY, !exp_w[i]);
            check("wp_awready", awr1, 1);
            check("wp_arready", arr1, 0);
            cyc();
        end
        AWVALID = 1'b0; ARVALID = 1'b0;
        cyc(); cyc();
        cmd_ready_i = 1'b0;

        // error classification
        send(1'b0, 32'h0, 8'd0, 3'd3, 2'b01, 1'b1, "err_size3");
        send(1'b0, 32'h0, 8'd5, 3'd2, 2'b10, 1'b1, "err_wraplen5");
        send(1'b0, 32'h8, 8'd1, 3'd2, 2'b10, 1'b0, "ok_wrap_aligned");
        send(1'b0, 32'h6, 8'd3, 3'd2, 2'b10, 1'b1, "err_wrap_unaligned");
        send(1'b0, 32'h0, 8'd0, 3'd2, 2'b11, 1'b1, "err_burst11");
`ifdef AXI2AHB_CMD_4K_CHECK_EN
        e4k = 1'b1;
`else
        e4k = 1'b0;
`endif
        send(1'b1, 32'hFF8, 8'd3, 3'd2, 2'b01, e4k, "cross_4k");
        send(1'b1, 32'hFF0, 8'd3, 3'd2, 2'b01, 1'b0, "fit_4k");

        // fill to depth, full blocks even with a pop, FIFO order across wrap
        do_reset();
        for (int k = 0; k < 4; k++) begin
            offer_w(32'h1000 + 32'(k * 4), 5, ok);
            check("fill_accept", ok, 1);
        end
        AWADDR = 32'h1010;
        @(negedge ACLK);
        check("fill_level", cmd_level_o, 4);
        check("fill_awready", AWREADY, 0);
        cyc();
        cmd_ready_i = 1'b1;
        @(negedge ACLK);
        check("full_pop_awready", AWREADY, 0);
        check("full_pop_head", cmd_addr_o, 32'h1000);
        cyc();
        cmd_ready_i = 1'b0;
        @(negedge ACLK);
        check("after_pop_level", cmd_level_o, 3);
        check("after_pop_awready", AWREADY, 1);
        cyc();
        AWVALID = 1'b0;
        @(negedge ACLK);
        check("refill_level", cmd_level_o, 4);
        cyc();
        cmd_ready_i = 1'b1;
        exp_a[0] = 32'h1004; exp_a[1] = 32'h1008; exp_a[2] = 32'h100C; exp_a[3] = 32'h1010;
        for (int k = 0; k < 4; k++) begin
            @(negedge ACLK);
            check("drain_order", cmd_addr_o, exp_a[k]);
            cyc();
        end
        cmd_ready_i = 1'b0;
        @(negedge ACLK);
        check("drained_valid", cmd_valid_o, 0);
        cyc();

        // reset with entries queued
        for (int k = 0; k < 3; k++) begin
            offer_w(32'h2000 + 32'(k * 4), 5, ok);
            check("pre_rst_accept", ok, 1);
        end
        ARVALID = 1'b1;
        ARESETN = 1'b0;
        #1;
        check("midrst_valid", cmd_valid_o, 0);
        check("midrst_level", cmd_level_o, 0);
        check("midrst_awready", AWREADY, 0);
        check("midrst_arready", ARREADY, 0);
        AWVALID = 1'b0; ARVALID = 1'b0;
        cyc(); cyc();
        ARESETN = 1'b1;
        @(negedge ACLK);
        check("post_rst_valid", cmd_valid_o, 0);
        check("post_rst_level", cmd_level_o, 0);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
